// File: rtl/program_store_if.sv
// Load stream, status and instruction fetch signals between the program loader
// and its neighbours.
interface program_store_if #(
  parameter int unsigned ADDR_W = 5
);
  logic              load_start;
  logic              load_valid;
  logic [7:0]        load_data;
  logic              load_last;
  logic              load_ready;
  logic              load_done;
  logic [ADDR_W:0]   prog_length;
  logic [1:0]        state;
  logic              cpu_reset;
  logic [7:0]        instruction_address;
  logic [7:0]        instruction;

  modport slave (
    input  load_start, load_valid, load_data, load_last, instruction_address,
    output load_ready, load_done, prog_length, state, cpu_reset, instruction
  );

  modport master (
    output load_start, load_valid, load_data, load_last, instruction_address,
    input  load_ready, load_done, prog_length, state, cpu_reset, instruction
  );
endinterface

// File: rtl/program_store.sv
// Flop-based instruction memory with a valid/ready program loader; holds the
// core in reset until a program has been loaded.
module program_store #(
  parameter int unsigned DEPTH  = 32,
  parameter int unsigned ADDR_W = 5,
  parameter logic [7:0]  FILL   = 8'hC3
) (
  input  logic          oscillator,
  input  logic          reset,
  program_store_if.slave bus
);

  localparam int unsigned LEN_W = ADDR_W + 1;
  localparam logic [ADDR_W-1:0] LAST_IDX  = ADDR_W'(DEPTH - 1);
  localparam logic [LEN_W-1:0]  LEN_MAX   = LEN_W'(DEPTH);
  localparam logic [8:0]        ADDR_LIM  = 9'(DEPTH);

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_LOAD = 2'b01,
    ST_RUN  = 2'b10
  } state_t;

  state_t            state_q,  state_d;
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [LEN_W-1:0]  len_q,    len_d;
  logic              ready_q,  ready_d;
  logic              done_q,   done_d;
  logic              cpu_rst_q, cpu_rst_d;
  logic [7:0]        mem_q [DEPTH];
  logic [7:0]        mem_d [DEPTH];

  // State register and storage
  always_ff @(posedge oscillator or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      wr_ptr_q  <= '0;
      len_q     <= '0;
      ready_q   <= 1'b0;
      done_q    <= 1'b0;
      cpu_rst_q <= 1'b1;
      mem_q     <= '{default: FILL};
    end else begin
      state_q   <= state_d;
      wr_ptr_q  <= wr_ptr_d;
      len_q     <= len_d;
      ready_q   <= ready_d;
      done_q    <= done_d;
      cpu_rst_q <= cpu_rst_d;
      mem_q     <= mem_d;
    end
  end

  // Next-state, storage update and registered output values
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    len_d     = len_q;
    ready_d   = 1'b0;
    done_d    = 1'b0;
    cpu_rst_d = 1'b1;
    mem_d     = mem_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.load_start) begin
          state_d  = ST_LOAD;
          wr_ptr_d = '0;
          len_d    = '0;
          ready_d  = 1'b1;
          mem_d    = '{default: FILL};
        end
      end

      ST_LOAD: begin
        ready_d = 1'b1;
        if (bus.load_valid && ready_q) begin
          mem_d[wr_ptr_q] = bus.load_data;
          if (len_q != LEN_MAX) len_d = len_q + LEN_W'(1);
          // The final entry ends the load, so the pointer never wraps.
          if (bus.load_last || (wr_ptr_q == LAST_IDX)) begin
            state_d   = ST_RUN;
            ready_d   = 1'b0;
            done_d    = 1'b1;
            cpu_rst_d = 1'b0;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end

      ST_RUN: begin
        cpu_rst_d = 1'b0;
        if (bus.load_start) begin
          state_d   = ST_LOAD;
          wr_ptr_d  = '0;
          len_d     = '0;
          ready_d   = 1'b1;
          cpu_rst_d = 1'b1;
          mem_d     = '{default: FILL};
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  assign bus.state       = state_q;
  assign bus.load_ready  = ready_q;
  assign bus.load_done   = done_q;
  assign bus.prog_length = len_q;
  assign bus.cpu_reset   = cpu_rst_q;

  // Zero-latency fetch; addresses beyond the storage read the halt word
  assign bus.instruction = ({1'b0, bus.instruction_address} < ADDR_LIM)
                           ? mem_q[bus.instruction_address[ADDR_W-1:0]]
                           : FILL;

endmodule

// File: tb/tb_program_store.sv
// Self-checking bench for program_store: directed vector table, hand-written
// corner sequences and randomized traffic against a queue-based program model.
module tb_program_store;

  localparam int unsigned ADDR_W = 5;
  localparam int unsigned DEPTH  = 32;
  localparam logic [7:0]  FILL   = 8'hC3;

  logic oscillator = 1'b0;
  logic reset;

  program_store_if #(.ADDR_W(ADDR_W)) bus ();

  program_store #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .FILL(FILL)) dut (
    .oscillator (oscillator),
    .reset      (reset),
    .bus        (bus)
  );

  always #5 oscillator = ~oscillator;

  int errors = 0;
  int checks = 0;

  // Reference model: the program is the list of bytes accepted so far.
  int         m_mode;     // 0 idle, 1 loading, 2 running
  logic [7:0] m_prog[$];
  bit         m_done;

  typedef struct {
    bit         start;
    bit         valid;
    logic [7:0] data;
    bit         last;
    logic [1:0] st;
    bit         rdy;
    bit         done;
    bit         cpu;
    logic [5:0] len;
    logic [7:0] i0;
  } vec_t;

  vec_t tbl[7];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] m_instr(input logic [7:0] a);
    if (int'(a) < m_prog.size()) return m_prog[a];
    return FILL;
  endfunction

  task automatic check_all();
    chk("state",       32'(bus.state),       32'(m_mode));
    chk("load_ready",  32'(bus.load_ready),  32'(m_mode == 1));
    chk("load_done",   32'(bus.load_done),   32'(m_done));
    chk("prog_length", 32'(bus.prog_length), 32'(m_prog.size()));
    chk("cpu_reset",   32'(bus.cpu_reset),   32'(m_mode != 2));
    chk("instruction", 32'(bus.instruction), 32'(m_instr(bus.instruction_address)));
  endtask

  task automatic cycle(input bit s, input bit v, input logic [7:0] d, input bit l);
    bus.load_start = s;
    bus.load_valid = v;
    bus.load_data  = d;
    bus.load_last  = l;
    @(posedge oscillator);
    m_done = 1'b0;
    if (m_mode == 1) begin
      if (v) begin
        m_prog.push_back(d);
        if (l || m_prog.size() == DEPTH) begin
          m_mode = 2;
          m_done = 1'b1;
        end
      end
    end else if (s) begin
      m_prog.delete();
      m_mode = 1;
    end
    #1;
    check_all();
  endtask

  task automatic peek(input logic [7:0] a, input logic [7:0] exp);
    bus.instruction_address = a;
    cycle(1'b0, 1'b0, 8'h00, 1'b0);
    chk("instr_at_addr", 32'(bus.instruction), 32'(exp));
  endtask

  task automatic do_reset();
    bus.load_start = 1'b0;
    bus.load_valid = 1'b0;
    bus.load_data  = 8'h00;
    bus.load_last  = 1'b0;
    reset = 1'b1;
    #1;
    m_mode = 0;
    m_prog.delete();
    m_done = 1'b0;
    chk("rst_state",     32'(bus.state),       32'd0);
    chk("rst_cpu_reset", 32'(bus.cpu_reset),   32'd1);
    chk("rst_ready",     32'(bus.load_ready),  32'd0);
    chk("rst_done",      32'(bus.load_done),   32'd0);
    chk("rst_length",    32'(bus.prog_length), 32'd0);
    @(posedge oscillator);
    #1;
    check_all();
    reset = 1'b0;
  endtask

  initial begin
    bus.instruction_address = 8'h00;
    m_mode = 0;
    m_done = 1'b0;

    // Load 05,46,C3 then restart a load from RUN
    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 6'd0, 8'hC3};
    tbl[1] = '{1'b0, 1'b1, 8'h05, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 6'd1, 8'h05};
    tbl[2] = '{1'b0, 1'b1, 8'h46, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 6'd2, 8'h05};
    tbl[3] = '{1'b0, 1'b1, 8'hC3, 1'b1, 2'b10, 1'b0, 1'b1, 1'b0, 6'd3, 8'h05};
    tbl[4] = '{1'b0, 1'b1, 8'h77, 1'b0, 2'b10, 1'b0, 1'b0, 1'b0, 6'd3, 8'h05};
    tbl[5] = '{1'b1, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 6'd0, 8'hC3};
    tbl[6] = '{1'b0, 1'b0, 8'h00, 1'b0, 2'b01, 1'b1, 1'b0, 1'b1, 6'd0, 8'hC3};

    // Reset values and fill contents
    do_reset();
    peek(8'd0, 8'hC3);
    peek(8'd31, 8'hC3);

    // Table-driven load and reload from RUN
    for (int i = 0; i < 7; i++) begin
      bus.instruction_address = 8'h00;
      cycle(tbl[i].start, tbl[i].valid, tbl[i].data, tbl[i].last);
      chk($sformatf("tbl%0d_state", i), 32'(bus.state),       32'(tbl[i].st));
      chk($sformatf("tbl%0d_ready", i), 32'(bus.load_ready),  32'(tbl[i].rdy));
      chk($sformatf("tbl%0d_done", i),  32'(bus.load_done),   32'(tbl[i].done));
      chk($sformatf("tbl%0d_cpu", i),   32'(bus.cpu_reset),   32'(tbl[i].cpu));
      chk($sformatf("tbl%0d_len", i),   32'(bus.prog_length), 32'(tbl[i].len));
      chk($sformatf("tbl%0d_i0", i),    32'(bus.instruction), 32'(tbl[i].i0));
    end

    // Same program with two idle cycles before every byte
    do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b0, 8'hAA, 1'b1);
      cycle(1'b0, 1'b0, 8'hAA, 1'b1);
      cycle(1'b0, 1'b1, (i == 0) ? 8'h05 : (i == 1) ? 8'h46 : 8'hC3, i == 2);
    end
    chk("gap_state",  32'(bus.state),       32'd2);
    chk("gap_done",   32'(bus.load_done),   32'd1);
    chk("gap_length", 32'(bus.prog_length), 32'd3);
    peek(8'd0, 8'h05);
    peek(8'd1, 8'h46);
    peek(8'd2, 8'hC3);
    peek(8'd3, 8'hC3);

    // Overflow cap: 32 bytes without load_last
    do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 32; i++) begin
      cycle(1'b0, 1'b1, 8'(i), 1'b0);
      if (i == 30) chk("ovf_ready_31", 32'(bus.load_ready), 32'd1);
    end
    chk("ovf_state",  32'(bus.state),       32'd2);
    chk("ovf_length", 32'(bus.prog_length), 32'd32);
    chk("ovf_done",   32'(bus.load_done),   32'd1);
    chk("ovf_ready",  32'(bus.load_ready),  32'd0);
    cycle(1'b0, 1'b1, 8'hEE, 1'b0);
    chk("ovf33_length", 32'(bus.prog_length), 32'd32);
    chk("ovf33_done",   32'(bus.load_done),   32'd0);
    peek(8'd0, 8'h00);
    peek(8'd31, 8'h1F);
    peek(8'd40, 8'hC3);

    // Reset in the middle of a load
    do_reset();
    cycle(1'b1, 1'b0, 8'h00, 1'b0);
    cycle(1'b0, 1'b1, 8'h05, 1'b0);
    cycle(1'b0, 1'b1, 8'h46, 1'b0);
    bus.instruction_address = 8'h00;
    do_reset();
    chk("midrst_addr0", 32'(bus.instruction), 32'hC3);
    for (int i = 0; i < 3; i++) begin
      cycle(1'b0, 1'b1, 8'hC3, 1'b1);
      chk("midrst_done", 32'(bus.load_done), 32'd0);
    end

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        bus.instruction_address = ($urandom_range(0, 3) == 0) ? 8'($urandom_range(0, 255))
                                                               : 8'($urandom_range(0, 33));
        cycle($urandom_range(0, 15) == 0, 1'($urandom_range(0, 1)),
              8'($urandom), $urandom_range(0, 7) == 0);
      end
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/program_store.md
Name: program_store

Overview:
- Instruction memory and program loader upstream of the 8-bit processor core.
- Accepts a program over a valid/ready byte stream and stores it in flop-based storage.
- Serves the core's instruction_address combinationally with the 8-bit instruction.
- Holds the core in reset (cpu_reset) while a program is being loaded.

Parameters:
DEPTH, 32, number of 8-bit instruction words stored; must equal 2**ADDR_W.
ADDR_W, 5, address width of storage.
FILL, 8'hC3, fill word for unloaded and out-of-range locations (jump -1 = self-loop halt).

Ports:
oscillator  input  1  clock; all state updates on rising edge.
reset  input  1  asynchronous, active-high reset.
load_start  input  1  one-cycle request to begin a new load.
load_valid  input  1  load_data/load_last are valid this cycle.
load_data  input  8  instruction byte to store.
load_last  input  1  marks the final byte of the program.
load_ready  output  1  block accepts a byte this cycle.
load_done  output  1  one-cycle pulse when a load completes.
prog_length  output  ADDR_W+1  number of words written by the last load.
state  output  2  00 IDLE, 01 LOAD, 10 RUN.
cpu_reset  output  1  reset to the processor core; high in IDLE and LOAD.
instruction_address  input  8  fetch address (core PC).
instruction  output  8  instruction word at instruction_address.

Behaviour:
- Reset (async, immediate):
  - state=IDLE, cpu_reset=1, load_ready=0, load_done=0, prog_length=0, wr_ptr=0.
  - All DEPTH entries set to FILL.
- Read path: purely combinational, no latency.
  - instruction = mem[instruction_address[ADDR_W-1:0]] when instruction_address < DEPTH, else FILL.
  - Valid in every state.
- IDLE:
  - cpu_reset=1, load_ready=0.
  - load_start=1 -> next state LOAD; wr_ptr=0, prog_length=0, all entries rewritten to FILL on the same edge.
- LOAD:
  - load_ready=1 (registered: high from the first cycle in LOAD).
  - Transfer occurs only when load_valid && load_ready; then mem[wr_ptr]=load_data, wr_ptr+1, prog_length+1.
  - No transfer when load_valid=0; nothing written, counters hold.
  - Exit to RUN on the edge of a transfer with load_last=1, or of the transfer into entry DEPTH-1 (overflow cap).
  - On exit, load_ready=0 the next cycle; no further bytes are accepted.
  - load_start is ignored in LOAD.
- RUN:
  - cpu_reset=0 from the first cycle in RUN; load_ready=0.
  - load_done=1 for exactly the first cycle in RUN, then 0.
  - load_start=1 -> LOAD with the same clearing as from IDLE.
  - cpu_reset returns to 1 on the same edge, so the core is held in reset before any new byte is written.
- cpu_reset is a registered output; it is never combinationally derived from inputs.
- Width rules:
  - wr_ptr is ADDR_W bits and never wraps; the overflow cap exits LOAD before wrap.
  - prog_length saturates at DEPTH (6'd32 for default parameters).
- Reset mid-load: the partial program is discarded, all outputs return to reset values, and no load_done is issued.
- load_valid while not in LOAD: ignored, no writes.

Test Plan:
1. Assert reset -> state=00, cpu_reset=1, load_ready=0, prog_length=0; addr 0 and addr 31 read 0xC3.
2. load_start, then bytes 0x05, 0x46, 0xC3 with load_last on the third ->
   - load_done pulses one cycle; state=10; prog_length=3; cpu_reset=0.
   - addr0=0x05, addr1=0x46, addr2=0xC3, addr3=0xC3.
3. Same load with load_valid low for 2 cycles between every byte -> identical final contents and prog_length=3; no extra writes.
4. 32 bytes 0x00..0x1F, load_last never asserted ->
   - RUN after the 32nd transfer; prog_length=32; load_ready=0 afterwards.
   - A 33rd load_valid is not stored; addr 40 reads 0xC3.
5. In RUN after test 2, pulse load_start -> cpu_reset=1 and state=01 next cycle; addr0 reads 0xC3 before any new byte.
6. Assert reset after 2 of 3 bytes loaded -> state=00, addr0=0xC3, prog_length=0, load_done stays 0.
